// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, registered flags
// and an internal carry flag so that ADC/SBB can chain multi-word arithmetic.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_neg,
  output logic             alu_ovf
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_INC = 4'h3,
    OP_DEC = 4'h4, OP_OR  = 4'h5, OP_AND = 4'h6, OP_XOR = 4'h7,
    OP_SHR = 4'h8, OP_SHL = 4'h9, OP_NOT = 4'hA, OP_NEG = 4'hB,
    OP_ADC = 4'hC, OP_SBB = 4'hD, OP_ROL = 4'hE, OP_ROR = 4'hF
  } op_e;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
  endfunction

  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  op_e              op_p1;
  logic             vld_p1;
  logic             carry_flag;

  logic             s2_free;
  logic             advance;
  logic             accept;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             res_cy;
  logic             res_ov;

  assign s2_free  = !out_valid || out_ready;
  assign advance  = vld_p1 && s2_free;
  assign in_ready = !vld_p1 || s2_free;
  assign accept   = in_valid && in_ready;

  // Arithmetic ops run at WIDTH+1 bits so the carry/borrow falls out as the top bit.
  always_comb begin
    ext    = '0;
    res    = '0;
    res_cy = 1'b0;
    res_ov = 1'b0;
    case (op_p1)
      OP_NOP: ;
      OP_ADD: begin
        ext    = {1'b0, a_p1} + {1'b0, b_p1};
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
        res_ov = add_ovf(a_p1, b_p1, res);
      end
      OP_SUB: begin
        ext    = {1'b0, a_p1} - {1'b0, b_p1};
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
        res_ov = sub_ovf(a_p1, b_p1, res);
      end
      OP_INC: begin
        ext    = {1'b0, a_p1} + ONE;
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a_p1} - ONE;
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
      end
      OP_OR:  res = a_p1 | b_p1;
      OP_AND: res = a_p1 & b_p1;
      OP_XOR: res = a_p1 ^ b_p1;
      OP_SHR: begin
        res    = {1'b0, a_p1[MSB:1]};
        res_cy = a_p1[0];
      end
      OP_SHL: begin
        res    = {a_p1[MSB-1:0], 1'b0};
        res_cy = a_p1[MSB];
      end
      OP_NOT: res = ~a_p1;
      OP_NEG: begin
        ext    = {1'b0, ~a_p1} + ONE;
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
      end
      OP_ADC: begin
        ext    = {1'b0, a_p1} + {1'b0, b_p1} + {{WIDTH{1'b0}}, carry_flag};
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
        res_ov = add_ovf(a_p1, b_p1, res);
      end
      OP_SBB: begin
        ext    = {1'b0, a_p1} - {1'b0, b_p1} - {{WIDTH{1'b0}}, carry_flag};
        res    = ext[MSB:0];
        res_cy = ext[WIDTH];
        res_ov = sub_ovf(a_p1, b_p1, res);
      end
      OP_ROL: begin
        res    = {a_p1[MSB-1:0], a_p1[MSB]};
        res_cy = a_p1[MSB];
      end
      OP_ROR: begin
        res    = {a_p1[0], a_p1[MSB:1]};
        res_cy = a_p1[0];
      end
      default: ;
    endcase
  end

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= in_a;
      b_p1  <= in_b;
      op_p1 <= op_e'(opcode);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (advance) vld_p1 <= 1'b0;
  end

  // S2: result and flags; the carry flag tracks every computed op in acceptance order
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      carry_flag <= 1'b0;
      alu_out    <= '0;
      alu_zero   <= 1'b1;
      alu_carry  <= 1'b0;
      alu_neg    <= 1'b0;
      alu_ovf    <= 1'b0;
    end else if (advance) begin
      out_valid  <= 1'b1;
      carry_flag <= res_cy;
      alu_out    <= res;
      alu_zero   <= (res == '0);
      alu_carry  <= res_cy;
      alu_neg    <= res[MSB];
      alu_ovf    <= res_ov;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an 8-bit instance under directed and random traffic with a
// scoreboard, plus a 16-bit instance for the shift/rotate/negate cases.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, alu_out;
  logic [3:0] opcode;
  logic       alu_zero, alu_carry, alu_neg, alu_ovf;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16, alu_out16;
  logic [3:0]  opcode16;
  logic        alu_zero16, alu_carry16, alu_neg16, alu_ovf16;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_neg(alu_neg), .alu_ovf(alu_ovf));

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .opcode(opcode16), .out_valid(out_valid16),
    .out_ready(out_ready16), .alu_out(alu_out16), .alu_zero(alu_zero16),
    .alu_carry(alu_carry16), .alu_neg(alu_neg16), .alu_ovf(alu_ovf16));

  typedef struct {
    longint r;
    bit     cy, ov, z, n;
    int     acc;
  } exp_t;

  exp_t   q[$];
  bit     c_m, c16_m;
  int     cyc;
  int     n_cmp, n_bad;

  task automatic check_val(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference ALU using plain integer arithmetic; signed overflow is an out-of-range
  // signed result.
  task automatic ref_op(input int w, input int op, input longint a, input longint b,
                        input bit cin, output exp_t e);
    longint m, half, full, sa, sb, sf;
    bit     cy, ov;
    m = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    cy = 0; ov = 0; full = 0; sf = 0;
    case (op)
      1:  begin full = a + b; cy = full >= m; sf = sa + sb; ov = (sf < -half) || (sf >= half); end
      2:  begin full = a - b; cy = a < b; sf = sa - sb; ov = (sf < -half) || (sf >= half); end
      3:  begin full = a + 1; cy = (a == m - 1); end
      4:  begin full = a - 1; cy = (a == 0); end
      5:  full = a | b;
      6:  full = a & b;
      7:  full = a ^ b;
      8:  begin full = a / 2; cy = a[0]; end
      9:  begin full = a * 2; cy = a >= half; end
      10: full = (m - 1) - a;
      11: begin full = m - a; cy = (a == 0); end
      12: begin full = a + b + cin; cy = full >= m;
                sf = sa + sb + cin; ov = (sf < -half) || (sf >= half); end
      13: begin full = a - b - cin; cy = a < b + cin;
                sf = sa - sb - cin; ov = (sf < -half) || (sf >= half); end
      14: begin full = a * 2 + ((a >= half) ? 1 : 0); cy = a >= half; end
      15: begin full = a / 2 + (a[0] ? half : 0); cy = a[0]; end
      default: full = 0;
    endcase
    e.r   = ((full % m) + m) % m;
    e.cy  = cy;
    e.ov  = ov;
    e.z   = (e.r == 0);
    e.n   = (e.r >= half);
    e.acc = 0;
  endtask

  // One cycle on the 8-bit instance: drive, then check what the next edge will do.
  task automatic step(input bit v, input int op, input int a, input int b, input bit ordy,
                      output bit accepted);
    exp_t e;
    bit   want_ov;
    @(negedge clk);
    in_valid = v; opcode = 4'(op); in_a = 8'(a); in_b = 8'(b); out_ready = ordy;
    #1;
    check_val("in_ready", in_ready, !(q.size() == 2 && !ordy));
    want_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    check_val("out_valid", out_valid, want_ov);
    if (out_valid && want_ov) begin
      check_val("alu_out", alu_out, q[0].r);
      check_val("alu_carry", alu_carry, q[0].cy);
      check_val("alu_ovf", alu_ovf, q[0].ov);
      check_val("alu_zero", alu_zero, q[0].z);
      check_val("alu_neg", alu_neg, q[0].n);
    end
    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    accepted = in_valid && in_ready;
    if (accepted) begin
      ref_op(8, op, longint'(in_a), longint'(in_b), c_m, e);
      e.acc = cyc;
      c_m = e.cy;
      q.push_back(e);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_valid16 = 0; out_ready = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    c_m = 0; c16_m = 0;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_alu_out", alu_out, 0);
    check_val("rst_zero", alu_zero, 1);
    check_val("rst_carry", alu_carry, 0);
    check_val("rst_neg", alu_neg, 0);
    check_val("rst_ovf", alu_ovf, 0);
    cyc += 2;
  endtask

  task automatic op16(input int op, input int a, input int b);
    exp_t e;
    @(negedge clk);
    in_valid16 = 1; opcode16 = 4'(op); in_a16 = 16'(a); in_b16 = 16'(b);
    #1;
    check_val("w16_in_ready", in_ready16, 1);
    ref_op(16, op, longint'(a), longint'(b), c16_m, e);
    c16_m = e.cy;
    @(negedge clk);
    in_valid16 = 0;
    @(negedge clk);
    #1;
    check_val("w16_out_valid", out_valid16, 1);
    check_val("w16_alu_out", alu_out16, e.r);
    check_val("w16_carry", alu_carry16, e.cy);
    check_val("w16_zero", alu_zero16, e.z);
    check_val("w16_neg", alu_neg16, e.n);
    check_val("w16_ovf", alu_ovf16, e.ov);
  endtask

  initial begin
    bit acc;
    int tries;
    rst = 0; in_valid = 0; in_a = 0; in_b = 0; opcode = 0; out_ready = 1;
    in_valid16 = 0; in_a16 = 0; in_b16 = 0; opcode16 = 0; out_ready16 = 1;
    n_cmp = 0; n_bad = 0; cyc = 0; c_m = 0; c16_m = 0;

    do_reset();

    // 16-bit shifts, rotates and negate
    op16(14, 16'h8001, 0);
    op16(8, 16'h0001, 0);
    op16(11, 16'h0000, 0);
    op16(9, 16'h8000, 0);
    op16(15, 16'h0001, 0);
    op16(12, 16'hFFFF, 16'h0000);

    // Multi-word add, overflow and borrow, back to back
    step(1, 1, 8'hFF, 8'h01, 1, acc);
    step(1, 12, 8'h00, 8'h00, 1, acc);
    step(1, 1, 8'h7F, 8'h01, 1, acc);
    step(1, 2, 8'h00, 8'h01, 1, acc);
    step(1, 13, 8'h80, 8'h01, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);

    // Backpressure: two ops fill the pipe, the third waits for out_ready
    step(1, 3, 8'h01, 0, 0, acc);
    check_val("bp_accept1", acc, 1);
    step(1, 4, 8'h00, 0, 0, acc);
    check_val("bp_accept2", acc, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 8'hAA, 8'h55, 0, acc);
      check_val("bp_blocked", acc, 0);
    end
    step(1, 7, 8'hAA, 8'h55, 1, acc);
    check_val("bp_accept3", acc, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);
    check_val("bp_drained", q.size(), 0);

    // Reset with two ops in flight and the carry flag set
    step(1, 1, 8'hFF, 8'h01, 0, acc);
    step(1, 1, 8'hFF, 8'h01, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    do_reset();
    step(1, 12, 8'h01, 8'h01, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);

    // Random traffic with random stalls and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 2) != 0, acc);
    end

    tries = 0;
    while (q.size() > 0 && tries < 20) begin
      step(0, 0, 0, 0, 1, acc);
      tries++;
    end
    check_val("final_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
